mem_arbiter: RTL and testbench

- Sits directly downstream of the instruction and data caches; merges their memory-side traffic onto one shared main-memory port with fixed access latency.
- Per-port req/ack handshake replaces the caches' direct combinational memory hookup.
- Drives a global stall while any access is outstanding, so the I-cache and D-cache each complete at most one memory access per CPU instruction.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/mem_arb_grant.sv | 26 ++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned NUM_PORTS  = 2;
  localparam int unsigned PORT_IDX_W = 1;

  localparam logic [PORT_IDX_W-1:0] PORT_ICACHE = 1'b0;
  localparam logic [PORT_IDX_W-1:0] PORT_DCACHE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arb_grant.sv
// Grant selection for the memory arbiter: fixed D-cache priority, or alternating
// under contention when MEM_ARB_ROUND_ROBIN_EN is defined.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0]  req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic [PORT_IDX_W-1:0] last_grant_i,
`endif
  output logic [PORT_IDX_W-1:0] grant_c
);

  always_comb begin
    grant_c = PORT_ICACHE;
    if (req_i[PORT_DCACHE]) begin
      grant_c = PORT_DCACHE;
    end
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Under contention, serve the port that was not served last.
    if (&req_i) begin
      grant_c = (last_grant_i == PORT_DCACHE) ? PORT_ICACHE : PORT_DCACHE;
    end
`endif
  end

endmodule

// File: rtl/mem_arbiter.sv
// Merges I-cache and D-cache accesses onto one fixed-latency memory port.
// Optional round-robin grant under contention via MEM_ARB_ROUND_ROBIN_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NUM_PORTS-1:0]                 req_i,
  input  logic [NUM_PORTS-1:0]                 wen_i,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_PORTS-1:0]                 ack_o,
  output logic [DATA_WIDTH-1:0]                rdata_o,
  output logic                                 stall_o,
  output logic [ADDR_WIDTH-1:0]                mem_addr_o,
  output logic [DATA_WIDTH-1:0]                mem_wdata_o,
  output logic                                 mem_wen_o,
  input  logic [DATA_WIDTH-1:0]                mem_rdata_i
);

  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PORT_IDX_W-1:0]   grant_q, grant_d;
  logic                    wen_q, wen_d;
  logic [NUM_PORTS-1:0]    ack_q, ack_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    mem_wen_q, mem_wen_d;
  logic [PORT_IDX_W-1:0]   grant_c;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic [PORT_IDX_W-1:0]   last_grant_q, last_grant_d;
`endif

  mem_arb_grant u_grant (
    .req_i        (req_i),
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_grant_i (last_grant_q),
`endif
    .grant_c      (grant_c)
  );

  // State register and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      grant_q     <= PORT_ICACHE;
      wen_q       <= 1'b0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wen_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      wen_q       <= wen_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wen_q   <= mem_wen_d;
    end
  end

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_grant_q <= PORT_ICACHE;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  // Next-state and output logic; mem_addr/wdata registers double as the operand latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_d     = grant_q;
    wen_d       = wen_q;
    ack_d       = '0;
    rdata_d     = rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wen_d   = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    case (state_q)
      ST_IDLE: begin
        rdata_d     = '0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        if (|req_i) begin
          grant_d     = grant_c;
          wen_d       = wen_i[grant_c];
          mem_addr_d  = addr_i[grant_c];
          mem_wdata_d = wdata_i[grant_c];
          mem_wen_d   = wen_i[grant_c];
          cnt_d       = '0;
          state_d     = ST_BUSY;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_grant_d = grant_c;
`endif
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          rdata_d        = wen_q ? '0 : mem_rdata_i;
          ack_d[grant_q] = 1'b1;
          mem_addr_d     = '0;
          mem_wdata_d    = '0;
          cnt_d          = '0;
          state_d        = ST_DONE;
        end
      end
      ST_DONE: begin
        rdata_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ack_o       = ack_q;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_wen_o   = mem_wen_q;
  assign stall_o     = (|req_i) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (LATENCY=4 and LATENCY=1 instances).
module tb_mem_arbiter;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [31:0]       mem_rdata;

  logic [1:0]        req, wen, ack;
  logic [1:0][31:0]  addr, wdata;
  logic [31:0]       rdata, maddr, mwdata;
  logic              stall, mwen;

  logic [1:0]        req1, wen1, ack1;
  logic [1:0][31:0]  addr1, wdata1;
  logic [31:0]       rdata1, maddr1, mwdata1;
  logic              stall1, mwen1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(.LATENCY(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req), .wen_i(wen), .addr_i(addr),
    .wdata_i(wdata), .ack_o(ack), .rdata_o(rdata), .stall_o(stall),
    .mem_addr_o(maddr), .mem_wdata_o(mwdata), .mem_wen_o(mwen),
    .mem_rdata_i(mem_rdata)
  );

  mem_arbiter #(.LATENCY(1), .ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut_l1 (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req1), .wen_i(wen1), .addr_i(addr1),
    .wdata_i(wdata1), .ack_o(ack1), .rdata_o(rdata1), .stall_o(stall1),
    .mem_addr_o(maddr1), .mem_wdata_o(mwdata1), .mem_wen_o(mwen1),
    .mem_rdata_i(mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Ticks from the request edge until ack (bounded), recording strobe and stall activity.
  task automatic wait_ack(output int n, output logic [1:0] a, output logic [31:0] rd,
                          output int wen_cnt, output logic [31:0] w_addr,
                          output logic [31:0] w_data, output int stall_lo);
    n = 0; a = '0; rd = '0; wen_cnt = 0; w_addr = '0; w_data = '0; stall_lo = 0;
    while (a == 2'b00 && n < 20) begin
      tick();
      n++;
      if (mwen) begin
        wen_cnt++;
        w_addr = maddr;
        w_data = mwdata;
      end
      if (!stall) stall_lo++;
      a  = ack;
      rd = rdata;
    end
  endtask

  int          n, wc, slo, leaked;
  logic [1:0]  a, exp_seq [4];
  logic [31:0] rd, wa, wd;

  initial begin
    rst_i = 1'b1;
    req = '0; wen = '0; addr = '0; wdata = '0;
    req1 = '0; wen1 = '0; addr1 = '0; wdata1 = '0;
    mem_rdata = 32'hDEAD_BEEF;
    tick(); tick();

    // Reset state
    check_eq("rst_ack", 64'(ack), 64'(0));
    check_eq("rst_rdata", 64'(rdata), 64'(0));
    check_eq("rst_mem_addr", 64'(maddr), 64'(0));
    check_eq("rst_mem_wen", 64'(mwen), 64'(0));
    check_eq("rst_stall_idle", 64'(stall), 64'(0));
    req = 2'b01;
    #1;
    check_eq("rst_stall_follows_req", 64'(stall), 64'(1));
    req = '0;
    #1;
    rst_i = 1'b0;
    tick();

    // I-cache read, LATENCY=4
    req = 2'b01; wen = 2'b00; addr[0] = 32'h0000_0040;
    tick();
    check_eq("rd_busy_addr", 64'(maddr), 64'h40);
    addr[0] = 32'hFFFF_FFFF;
    wait_ack(n, a, rd, wc, wa, wd, slo);
    check_eq("rd_ack_cycles", 64'(n + 1), 64'(5));
    check_eq("rd_ack", 64'(a), 64'(2'b01));
    check_eq("rd_rdata", 64'(rd), 64'hDEAD_BEEF);
    check_eq("rd_no_wen", 64'(wc), 64'(0));
    req = '0;
    tick();
    check_eq("rd_ack_pulse", 64'(ack), 64'(0));
    check_eq("rd_rdata_idle", 64'(rdata), 64'(0));

    // D-cache write
    req = 2'b10; wen = 2'b10; addr[1] = 32'h0000_1000; wdata[1] = 32'h1234_5678;
    wait_ack(n, a, rd, wc, wa, wd, slo);
    check_eq("wr_ack_cycles", 64'(n), 64'(5));
    check_eq("wr_ack", 64'(a), 64'(2'b10));
    check_eq("wr_rdata", 64'(rd), 64'(0));
    check_eq("wr_strobe_count", 64'(wc), 64'(1));
    check_eq("wr_strobe_addr", 64'(wa), 64'h1000);
    check_eq("wr_strobe_data", 64'(wd), 64'h1234_5678);
    req = '0; wen = '0;
    tick();

    // Reset pulse so the round-robin history starts at I-cache
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    tick();

    // Simultaneous reads: D-cache first, I-cache after one bubble
    req = 2'b11; addr[0] = 32'h40; addr[1] = 32'h80;
    wait_ack(n, a, rd, wc, wa, wd, slo);
    check_eq("both_first_cycles", 64'(n), 64'(5));
    check_eq("both_first_ack", 64'(a), 64'(2'b10));
    check_eq("both_first_stall", 64'(slo), 64'(0));
    req = 2'b01;
    wait_ack(n, a, rd, wc, wa, wd, slo);
    check_eq("both_second_cycles", 64'(n), 64'(6));
    check_eq("both_second_ack", 64'(a), 64'(2'b01));
    check_eq("both_second_stall", 64'(slo), 64'(0));
    req = '0;
    tick();

    // Both ports requesting continuously for four accesses
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq[0] = 2'b10; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10; exp_seq[3] = 2'b01;
`else
    exp_seq[0] = 2'b10; exp_seq[1] = 2'b10; exp_seq[2] = 2'b10; exp_seq[3] = 2'b10;
`endif
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_ack(n, a, rd, wc, wa, wd, slo);
      check_eq($sformatf("cont_ack_%0d", i), 64'(a), 64'(exp_seq[i]));
      check_eq($sformatf("cont_cycles_%0d", i), 64'(n), 64'((i == 0) ? 5 : 6));
    end
    req = '0;
    tick();

    // Reset on the second BUSY cycle of a read
    req = 2'b01; addr[0] = 32'h0000_0040;
    tick();
    tick();
    check_eq("abort_pre_addr", 64'(maddr), 64'h40);
    rst_i = 1'b1;
    #1;
    check_eq("abort_mem_addr", 64'(maddr), 64'(0));
    check_eq("abort_ack", 64'(ack), 64'(0));
    check_eq("abort_rdata", 64'(rdata), 64'(0));
    check_eq("abort_mem_wen", 64'(mwen), 64'(0));
    req = '0;
    tick();
    rst_i = 1'b0;
    leaked = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ack != 2'b00) leaked++;
    end
    check_eq("abort_no_ack", 64'(leaked), 64'(0));
    check_eq("abort_idle", 64'(stall), 64'(0));

    // LATENCY=1 read: data sampled in the single BUSY cycle
    req1 = 2'b01; wen1 = 2'b00; addr1[0] = 32'h0000_0200;
    tick();
    check_eq("l1_busy_addr", 64'(maddr1), 64'h200);
    check_eq("l1_busy_ack", 64'(ack1), 64'(0));
    mem_rdata = 32'hCAFE_F00D;
    tick();
    check_eq("l1_rd_ack", 64'(ack1), 64'(2'b01));
    check_eq("l1_rd_rdata", 64'(rdata1), 64'hCAFE_F00D);
    req1 = '0;
    tick();

    // LATENCY=1 write: strobe in the single BUSY cycle
    req1 = 2'b01; wen1 = 2'b01; addr1[0] = 32'h0000_0300; wdata1[0] = 32'hA5A5_5A5A;
    tick();
    check_eq("l1_wr_strobe", 64'(mwen1), 64'(1));
    check_eq("l1_wr_data", 64'(mwdata1), 64'hA5A5_5A5A);
    tick();
    check_eq("l1_wr_ack", 64'(ack1), 64'(2'b01));
    check_eq("l1_wr_rdata", 64'(rdata1), 64'(0));
    check_eq("l1_wr_strobe_off", 64'(mwen1), 64'(0));
    req1 = '0; wen1 = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
